// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default word width, channel encodings and the
// receiver framing states. Also used by the I2S transmitter.
package i2s_pkg;

    localparam int   WIDTH    = 16;
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/i2s_rx_if.sv
// Parallel side of the I2S receiver: held stereo pair with valid/ready
// handshake plus the overrun and framing-error pulses.
interface i2s_rx_if;
    import i2s_pkg::*;

    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic             valid;
    logic             ready;
    logic             overrun;
    logic             frame_err;

    modport master (
        output left, right, valid, overrun, frame_err,
        input  ready
    );

    modport slave (
        input  left, right, valid, overrun, frame_err,
        output ready
    );

endinterface

// File: rtl/i2s_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module i2s_sync (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;
    logic [1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[0], d};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ff_q <= '0;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/i2s_rx.sv
// Slave-mode I2S receiver: oversamples sclk/lrclk/sdout in the clk domain,
// deframes left/right words and presents completed pairs on a valid/ready bus.
module i2s_rx
    import i2s_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      sclk,
    input  logic      lrclk,
    input  logic      sdout,
    i2s_rx_if.master  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    logic sclk_s;
    logic lr_s;
    logic sd_s;

    i2s_sync u_sync_sclk (.clk(clk), .resetn(resetn), .d(sclk),  .q(sclk_s));
    i2s_sync u_sync_lr   (.clk(clk), .resetn(resetn), .d(lrclk), .q(lr_s));
    i2s_sync u_sync_sd   (.clk(clk), .resetn(resetn), .d(sdout), .q(sd_s));

    logic             sclk_dly_q,   sclk_dly_d;
    logic             edge_q,       edge_d;
    logic             lr_e_q,       lr_e_d;
    logic             sd_e_q,       sd_e_d;
    logic             prev_lr_q,    prev_lr_d;
    state_e           state_q,      state_d;
    logic [CW-1:0]    cnt_q,        cnt_d;
    logic [WIDTH-1:0] shreg_q,      shreg_d;
    logic [WIDTH-1:0] left_stage_q, left_stage_d;
    logic             left_ok_q,    left_ok_d;
    logic [WIDTH-1:0] left_q,       left_d;
    logic [WIDTH-1:0] right_q,      right_d;
    logic             valid_q,      valid_d;
    logic             overrun_q,    overrun_d;
    logic             frame_err_q,  frame_err_d;

    logic [WIDTH-1:0] word;
    logic             pair_done;

    // Word as it stands once the bit sampled on this edge is shifted in.
    assign word = {shreg_q[WIDTH-2:0], sd_e_q};

    always_comb begin
        sclk_dly_d   = sclk_s;
        edge_d       = sclk_s & ~sclk_dly_q;
        lr_e_d       = lr_s;
        sd_e_d       = sd_s;
        prev_lr_d    = prev_lr_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        left_stage_d = left_stage_q;
        left_ok_d    = left_ok_q;
        left_d       = left_q;
        right_d      = right_q;
        valid_d      = valid_q;
        overrun_d    = 1'b0;
        frame_err_d  = 1'b0;
        pair_done    = 1'b0;

        if (edge_q) begin
            prev_lr_d = lr_e_q;
            if (lr_e_q != prev_lr_q) begin
                // The bit on the slot-change edge is the tail of the old slot.
                if (state_q == SHIFT && cnt_q != '0) begin
                    frame_err_d = 1'b1;
                end
                state_d = SHIFT;
                cnt_d   = '0;
                // A fresh left slot invalidates any stale left word.
                if (lr_e_q == CH_LEFT) begin
                    left_ok_d = 1'b0;
                end
            end else if (state_q == SHIFT) begin
                shreg_d = word;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    if (lr_e_q == CH_LEFT) begin
                        left_stage_d = word;
                        left_ok_d    = 1'b1;
                    end else if (left_ok_q) begin
                        pair_done = 1'b1;
                        left_ok_d = 1'b0;
                    end
                end
            end
        end

        if (pair_done) begin
            if (!valid_q || bus.ready) begin
                left_d  = left_stage_q;
                right_d = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_dly_q   <= 1'b0;
            edge_q       <= 1'b0;
            lr_e_q       <= 1'b0;
            sd_e_q       <= 1'b0;
            prev_lr_q    <= 1'b0;
            state_q      <= SYNC;
            cnt_q        <= '0;
            shreg_q      <= '0;
            left_stage_q <= '0;
            left_ok_q    <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sclk_dly_q   <= sclk_dly_d;
            edge_q       <= edge_d;
            lr_e_q       <= lr_e_d;
            sd_e_q       <= sd_e_d;
            prev_lr_q    <= prev_lr_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            left_stage_q <= left_stage_d;
            left_ok_q    <= left_ok_d;
            left_q       <= left_d;
            right_q      <= right_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.left      = left_q;
    assign bus.right     = right_q;
    assign bus.valid     = valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: an I2S master model drives slots at sclk = clk/8,
// a slot-level reference predicts pairs and error counts.
module tb_i2s_rx;
    import i2s_pkg::*;

    logic clk;
    logic resetn;
    logic sclk;
    logic lrclk;
    logic sdout;

    i2s_rx_if bus ();

    i2s_rx dut (
        .clk    (clk),
        .resetn (resetn),
        .sclk   (sclk),
        .lrclk  (lrclk),
        .sdout  (sdout),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          len_l;
        int          len_r;
        int          nfr;
        bit          rdy;
        int          e_pairs;
        int          e_ovr;
        int          e_err;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    int          ovr_tot = 0;
    int          err_tot = 0;
    bit          prev_hold = 0;
    bit          prev_v = 0;
    logic [31:0] held;
    bit          probe = 0;
    bit          probe_armed = 0;
    int          rise_cyc = 0;
    int          vrise_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.valid && bus.ready) obs_q.push_back({bus.left, bus.right});
            if (bus.overrun) ovr_tot++;
            if (bus.frame_err) err_tot++;
            if (prev_hold && bus.valid) chk("held_stable", {bus.left, bus.right}, held);
            if (bus.valid && !prev_v && probe_armed) begin
                vrise_cyc   = cyc;
                probe_armed = 0;
            end
            prev_hold = bus.valid && !bus.ready;
            held      = {bus.left, bus.right};
            prev_v    = bus.valid;
        end else begin
            prev_hold = 0;
            prev_v    = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        #1;
        chk("rst_left",      32'(bus.left),      32'h0);
        chk("rst_right",     32'(bus.right),     32'h0);
        chk("rst_valid",     32'(bus.valid),     32'h0);
        chk("rst_overrun",   32'(bus.overrun),   32'h0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
        repeat (5) @(posedge clk);
        #1;
        resetn    = 1'b1;
        bus.ready = 1'b1;
    endtask

    // One lrclk slot of len sclk periods; period 0 is the slot-change bit,
    // periods 1..WIDTH carry the word MSB first, the rest is random filler.
    task automatic play(input logic lr, input logic [15:0] w, input int len, input int rst_at);
        for (int p = 0; p < len; p++) begin
            @(posedge clk);
            #1;
            sclk  = 1'b0;
            lrclk = lr;
            sdout = (p >= 1 && p <= WIDTH) ? w[WIDTH-p] : 1'($urandom);
            if (p == rst_at) reset_pulse();
            repeat (4) @(posedge clk);
            #1;
            sclk = 1'b1;
            if (probe && lr && p == WIDTH) begin
                rise_cyc    = cyc;
                probe_armed = 1;
                probe       = 0;
            end
            repeat (3) @(posedge clk);
        end
    endtask

    task automatic compare(input string tag, input int obs_base, input int ovr_base,
                           input int err_base, input int e_ovr, input int e_err);
        int n;
        n = obs_q.size() - obs_base;
        chk({tag, "_pair_count"}, 32'(n), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < n; k++)
            chk({tag, "_pair"}, obs_q[obs_base+k], exp_q[k]);
        chk({tag, "_overruns"},   32'(ovr_tot - ovr_base), 32'(e_ovr));
        chk({tag, "_frame_errs"}, 32'(err_tot - err_base), 32'(e_err));
    endtask

    vec_t vecs[4];
    int   ob, vb, eb;

    initial begin
        vecs[0] = '{16'haa00, 16'h55ff, 17, 17, 3, 1'b1, 3, 0, 0};
        vecs[1] = '{16'h8001, 16'h7ffe, 32, 32, 2, 1'b1, 2, 0, 0};
        vecs[2] = '{16'h1234, 16'hfedc, 64, 20, 2, 1'b1, 2, 0, 0};
        vecs[3] = '{16'hc35a, 16'h3ca5, 17, 17, 3, 1'b0, 1, 2, 0};

        resetn = 1'b0; sclk = 1'b0; lrclk = 1'b0; sdout = 1'b0; bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("init_left",      32'(bus.left),      32'h0);
        chk("init_right",     32'(bus.right),     32'h0);
        chk("init_valid",     32'(bus.valid),     32'h0);
        chk("init_overrun",   32'(bus.overrun),   32'h0);
        chk("init_frame_err", 32'(bus.frame_err), 32'h0);
        resetn = 1'b1;
        idle(2);

        // Lead-in right slot: synchronizes the receiver, its word has no left partner.
        ob = obs_q.size(); vb = ovr_tot; eb = err_tot;
        play(1'b1, 16'hbeef, 17, -1);
        idle(12);
        exp_q.delete();
        compare("leadin", ob, vb, eb, 0, 0);

        for (int i = 0; i < 4; i++) begin
            ob = obs_q.size(); vb = ovr_tot; eb = err_tot;
            bus.ready = vecs[i].rdy;
            if (i == 0) probe = 1;
            for (int f = 0; f < vecs[i].nfr; f++) begin
                play(CH_LEFT,  vecs[i].l ^ 16'(f), vecs[i].len_l, -1);
                play(CH_RIGHT, vecs[i].r ^ 16'(f), vecs[i].len_r, -1);
            end
            idle(12);
            if (!vecs[i].rdy) begin
                bus.ready = 1'b1;
                idle(4);
            end
            exp_q.delete();
            for (int k = 0; k < vecs[i].e_pairs; k++)
                exp_q.push_back({vecs[i].l ^ 16'(k), vecs[i].r ^ 16'(k)});
            compare($sformatf("vec%0d", i), ob, vb, eb, vecs[i].e_ovr, vecs[i].e_err);
            if (i == 0) chk("valid_latency", 32'(vrise_cyc - rise_cyc), 32'd4);
        end

        // Left slot cut to 10 sclk: one framing error, that frame is lost.
        ob = obs_q.size(); vb = ovr_tot; eb = err_tot;
        play(CH_LEFT,  16'h1111, 10, -1);
        play(CH_RIGHT, 16'h2222, 17, -1);
        play(CH_LEFT,  16'h3333, 17, -1);
        play(CH_RIGHT, 16'h4444, 17, -1);
        idle(12);
        exp_q.delete();
        exp_q.push_back({16'h3333, 16'h4444});
        compare("short_left", ob, vb, eb, 0, 1);

        // Reset in the middle of a left slot while a pair is held.
        bus.ready = 1'b0;
        play(CH_LEFT,  16'ha5a5, 17, -1);
        play(CH_RIGHT, 16'h5a5a, 17, -1);
        idle(12);
        chk("held_before_reset", 32'(bus.valid), 32'h1);
        ob = obs_q.size(); vb = ovr_tot; eb = err_tot;
        play(CH_LEFT,  16'h0f0f, 17, 6);
        play(CH_RIGHT, 16'h1357, 17, -1);
        play(CH_LEFT,  16'h2468, 17, -1);
        play(CH_RIGHT, 16'h9bdf, 17, -1);
        idle(12);
        exp_q.delete();
        exp_q.push_back({16'h2468, 16'h9bdf});
        compare("reset_mid_left", ob, vb, eb, 0, 0);

        // Stream picked up 8 bits before the end of a right slot.
        reset_pulse();
        ob = obs_q.size(); vb = ovr_tot; eb = err_tot;
        play(CH_RIGHT, 16'h7777, 9, -1);
        play(CH_LEFT,  16'habcd, 17, -1);
        play(CH_RIGHT, 16'hdcba, 17, -1);
        idle(12);
        exp_q.delete();
        exp_q.push_back({16'habcd, 16'hdcba});
        compare("mid_right_start", ob, vb, eb, 0, 1);

        // Random slot lengths and words against the slot-level reference.
        begin
            logic [15:0] rw[48];
            int          rl[48];
            int          e_err;
            bit          pend;
            logic [15:0] pword;
            int          bits;
            for (int s = 0; s < 48; s++) begin
                rw[s] = 16'($urandom);
                rl[s] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, WIDTH))
                                                    : int'($urandom_range(WIDTH + 1, 40));
            end
            exp_q.delete();
            e_err = 0; pend = 0; pword = '0;
            for (int s = 0; s < 48; s++) begin
                bits = rl[s] - 1;
                if (bits >= 1 && bits < WIDTH) e_err++;
                if (s % 2 == 0) begin
                    pend  = (bits >= WIDTH);
                    pword = rw[s];
                end else if (bits >= WIDTH && pend) begin
                    exp_q.push_back({pword, rw[s]});
                    pend = 0;
                end
            end
            ob = obs_q.size(); vb = ovr_tot; eb = err_tot;
            for (int s = 0; s < 48; s++)
                play((s % 2 == 0) ? CH_LEFT : CH_RIGHT, rw[s], rl[s], -1);
            idle(12);
            compare("random", ob, vb, eb, 0, e_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S receiver for the audio path: deserializes a 2-channel I2S stream from an external ADC/codec into parallel left/right sample pairs. It runs as a slave: sclk, lrclk and sdout come from off-chip and are oversampled in the system clk domain. Completed stereo pairs go to the core through a valid/ready holding register.

## Interface
- WIDTH, 16, sample bits per channel, MSB first
- clk  input  1  system clock; must be ≥ 4× the sclk frequency
- resetn  input  1  asynchronous, active-low reset
- sclk  input  1  I2S bit clock, asynchronous to clk
- lrclk  input  1  I2S word select: 0 = left, 1 = right; asynchronous
- sdout  input  1  I2S serial data from codec; asynchronous
- left  output  WIDTH  left sample of the held pair
- right  output  WIDTH  right sample of the held pair
- valid  output  1  held pair available
- ready  input  1  consumer accepts pair when valid && ready
- overrun  output  1  one-cycle pulse: a completed pair was dropped
- frame_err  output  1  one-cycle pulse: a channel slot ended before WIDTH bits

## Operation
- sclk, lrclk, sdout each pass through a 2-flop synchronizer; sclk also gets a delay flop for rising-edge detect. All further logic acts only on detected sclk rising edges ("edges").
- Each edge samples synchronized lrclk and sdout. lrclk differing from its value at the previous edge is a slot change.
- The data bit on the slot-change edge belongs to the previous slot and is ignored (I2S one-bit delay). The next WIDTH edges shift sdout into the shift register, MSB first. Edges past WIDTH are ignored until the next slot change, so 32- or 64-sclk slots are accepted.
- Slot change with bit count in 1..WIDTH-1: word discarded, frame_err pulses, and the new slot starts normally. A count of 0 is not an error.
- States: SYNC (after reset; ignore data until the first slot change), SHIFT (counting bits), DONE (WIDTH bits taken, waiting for slot change). Any slot change goes to SHIFT with count 0.
- Left word complete: store in left staging register and set left_ok.
- Right word complete while left_ok: pair complete, clear left_ok. Right word complete without left_ok: discard silently.
- Pair complete:
  - valid = 0, or valid && ready in the same cycle: load left/right, valid = 1.
  - valid && !ready: outputs unchanged, new pair dropped, overrun pulses.
- valid && ready with no new pair: valid = 0 next cycle. left/right hold their last values.
- Reset (async, any time): all registers 0, state SYNC. A partial frame is lost.

## Timing
- Reset values: left = 0, right = 0, valid = 0, overrun = 0, frame_err = 0.
- Pin sclk rise to internal edge: 3 clk cycles (2 sync + edge register).
- valid rises 1 clk after the internal edge that samples the right-channel LSB. Total is 4 clk cycles from the pin sclk rise.
- overrun and frame_err are single-cycle pulses, aligned with the cycle the pair or word would have been loaded.
- valid stays high until the handshake; left/right are stable while valid = 1.
- Minimum sclk high and low times are each ≥ 2 clk periods. Faster sclk is unsupported and unchecked.

## Structure
- Package i2s_pkg: default WIDTH, channel encodings CH_LEFT = 0 and CH_RIGHT = 1, state enum {SYNC, SHIFT, DONE}. The i2s transmitter shares this package.
- Sub-module i2s_sync: 2-flop synchronizer with async active-low reset, instantiated three times.
- Bit counter width: $clog2(WIDTH+1).

## Test plan
- Bench I2S master, sclk = clk/8, 16-sclk slots: left 16'haa00, right 16'h55ff, ready = 1. Required: valid pulses once per frame with left = aa00, right = 55ff; no error pulses.
- 32-sclk slots, left 16'h8001, right 16'h7ffe. Required: same values captured; bits 17..32 of each slot ignored.
- Stream starts mid-right-slot after reset. Required: first partial slot discarded; first valid pair is the first complete left+right with correct values.
- ready = 0 for 3 frames. Required: first pair held with valid = 1; overrun pulses exactly twice; after ready = 1, the first pair is read unchanged.
- Left slot cut to 10 sclk. Required: frame_err pulses once; that frame's pair is not output; the next full frame is output.
- resetn asserted mid-left-slot for 5 clk. Required: outputs return to 0 immediately; the next valid carries the first complete frame after release.
